cpu6_mmu_bus: RTL and testbench
===============================

# cpu6_mmu_bus

Memory-management and bus-cycle unit downstream of the CPU6 microcoded core. Accepts one logical 16-bit read or write request at a time, translates it through an internal 256-entry page table into an 18-bit physical address, runs a timed memory bus cycle with programmable wait states plus external stretch, and returns read data with a one-cycle response pulse. The CPU6 microcode loads the page-table base and entries through the write port.

## Interface
Parameters:
- WAIT_STATES, 2, extra access cycles beyond the first; 0..15 legal
- FRAME_BITS, 7, physical frame number width; physical address = FRAME_BITS + 11

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  CPU request present
- req_ready  out  1  high only in IDLE; transfer on req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  16  logical address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data, valid with rsp_valid
- rsp_fault  out  1  write-protect fault, valid with rsp_valid
- pt_base  in  3  map-set select (page table base register)
- pt_we  in  1  page-table entry write strobe
- pt_index  in  8  entry index
- pt_data  in  8  entry value: [6:0] frame, [7] write-protect
- mem_addr  out  18  physical address
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data
- mem_wait  in  1  stretches access while high

## Operation
- States: IDLE, XLATE, ACCESS, DONE.
- IDLE: req_ready=1. On handshake, latch req_write, req_addr, req_wdata, pt_base; go XLATE.
- XLATE: page-table index = {latched pt_base, req_addr[15:11]}; registered read of entry; go ACCESS (or DONE with fault, see Configuration).
- ACCESS: mem_addr = {entry[6:0], req_addr[10:0]}; mem_rd or mem_wr held high whole state; mem_wdata = latched wdata. Wait counter loads WAIT_STATES on entry, decrements each cycle; leave when counter = 0 and mem_wait = 0. Read data captured on the exiting edge.
- DONE: rsp_valid=1 for one cycle; rsp_rdata = captured data (0x00 for writes); go IDLE.
- Page-table writes accepted in any state. Same-cycle write and XLATE read of one entry: XLATE uses old value.
- Changing pt_base after handshake has no effect on the in-flight request.
- Address wrap: 0xFFFF → page 31, offset 0x7FF; no carry into frame.
- Reset (any state): next edge → IDLE; mem_rd, mem_wr, rsp_valid, rsp_fault = 0; mem_addr, mem_wdata, rsp_rdata = 0; in-flight request dropped, no response. Page-table contents unaffected by reset; power-up contents: entry n = n[4:0] (identity map of low 64 KB in every map set).

## Timing
- Handshake at edge T; XLATE cycle T+1; ACCESS T+2 .. T+2+WAIT_STATES (+ mem_wait stretch cycles); rsp_valid at T+3+WAIT_STATES with mem_wait low.
- WAIT_STATES=0: single ACCESS cycle, rsp_valid at T+3.
- mem_wait sampled only once counter = 0; ignored earlier.
- Next req_ready high the cycle after DONE; back-to-back throughput one request per 4+WAIT_STATES cycles.
- All outputs registered.

## Configuration
- CPU6_MMU_WP_EN defined: entry bit 7 is write-protect; a write to a protected page goes XLATE → DONE with no mem strobes, rsp_fault=1, rsp_rdata=0xFF, rsp_valid at T+2. Reads of protected pages proceed normally.
- Undefined: bit 7 stored but ignored; rsp_fault tied 0; all writes proceed.

## Structure
- Package cpu6_pkg: state enum, PAGE_SHIFT=11, LOGICAL_AW=16, PT_ENTRIES=256, entry field positions.
- Sub-module cpu6_page_ram: 256×8 single-write, registered-read RAM with read-old-on-collision.

## Test plan
- WAIT_STATES=2, identity map, read 0x1234 → mem_addr=0x01234, mem_rd high 3 cycles, mem_rdata=0x5A → rsp_valid at T+5, rsp_rdata=0x5A.
- Write pt_index=0x25 data=0x41, pt_base=1, write 0x2ABC data 0x77 → mem_addr=0x20ABC, mem_wr high, mem_wdata=0x77.
- mem_wait high 4 extra cycles during read → rsp_valid delayed exactly 4 cycles, data captured after wait drops.
- Logical 0xFFFF with entry 0x1F = 0x7F → mem_addr=0x3FFFF.
- Reset asserted during ACCESS → strobes low next edge, no rsp_valid, req_ready=1 after reset release.
- CPU6_MMU_WP_EN, entry 0x80|0x05, write 0x0010 → no mem_wr, rsp_valid at T+2 with rsp_fault=1; read same address succeeds with mem_addr=0x02810.

Source files
------------

// File: rtl/cpu6_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu6_pkg
//  Description : Shared types and constants for the CPU6 MMU / bus-cycle unit:
//                state encoding, address split, page-table entry layout and
//                the power-up image of the page table.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu6_pkg;

  // Bus-cycle sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XLATE  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Logical address split: upper bits select the page, lower bits pass through
  localparam int PAGE_SHIFT = 11;
  localparam int LOGICAL_AW = 16;

  // Page table geometry and entry layout
  localparam int PT_ENTRIES    = 256;
  localparam int PT_INDEX_W    = 8;
  localparam int PTE_W         = 8;
  localparam int PTE_FRAME_LSB = 0;
  localparam int PTE_WP_BIT    = 7;

  // Power-up table: entry n holds n[4:0], an identity map of the low 64 KB
  // repeated in every map set, write-protect clear.
  function automatic logic [PT_ENTRIES*PTE_W-1:0] pt_init_image();
    logic [PT_ENTRIES*PTE_W-1:0] img;
    img = '0;
    for (int n = 0; n < PT_ENTRIES; n++) begin
      img[n*PTE_W +: PTE_W] = {3'b000, 5'(n)};
    end
    return img;
  endfunction

  localparam logic [PT_ENTRIES*PTE_W-1:0] PT_INIT = pt_init_image();

endpackage
`default_nettype wire

// File: rtl/cpu6_page_ram.sv
`default_nettype none
// ============================================================================
//  Module      : cpu6_page_ram
//  Description : 256 x 8 page-table RAM, one write port and one registered
//                read port. A read and write to the same entry on the same
//                edge returns the old contents. Contents survive reset and
//                power up as the identity image from cpu6_pkg.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu6_page_ram
  import cpu6_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [PT_INDEX_W-1:0] i_waddr,
  input  logic [PTE_W-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [PT_INDEX_W-1:0] i_raddr,
  output logic [PTE_W-1:0]      o_rdata
);

  // Flat storage so the power-up image can be given as a single constant
  logic [PT_ENTRIES*PTE_W-1:0] r_mem = PT_INIT;
  logic [PTE_W-1:0]            r_rdata;

  // Write and registered read share one edge; non-blocking update gives read-old
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[{i_waddr, 3'b000} +: PTE_W] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[{i_raddr, 3'b000} +: PTE_W];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cpu6_mmu_bus.sv
`default_nettype none
// ============================================================================
//  Module      : cpu6_mmu_bus
//  Description : Translates one 16-bit logical request at a time through the
//                page table into a FRAME_BITS+11 bit physical address and runs
//                a memory bus cycle with WAIT_STATES extra cycles plus
//                mem_wait stretch. Returns a one-cycle response pulse.
//                Optional feature macro: CPU6_MMU_WP_EN (entry bit 7 acts as
//                write-protect; protected writes fault without a bus cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu6_mmu_bus #(
  parameter int WAIT_STATES = 2,
  parameter int FRAME_BITS  = 7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [15:0]           req_addr,
  input  logic [7:0]            req_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic                  rsp_fault,
  input  logic [2:0]            pt_base,
  input  logic                  pt_we,
  input  logic [7:0]            pt_index,
  input  logic [7:0]            pt_data,
  output logic [FRAME_BITS+10:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_wait
);
  import cpu6_pkg::*;

  state_t                    r_state;
  logic                      r_ready;
  logic                      r_write;
  logic [PAGE_SHIFT-1:0]     r_off;
  logic [3:0]                r_cnt;
  logic [FRAME_BITS+10:0]    r_mem_addr;
  logic                      r_mem_rd;
  logic                      r_mem_wr;
  logic [7:0]                r_mem_wdata;
  logic                      r_rsp_valid;
  logic [7:0]                r_rsp_rdata;
  logic                      r_rsp_fault;

  logic                      w_hs;
  logic [PT_INDEX_W-1:0]     w_pt_rd_idx;
  logic [PTE_W-1:0]          w_entry;
  logic [FRAME_BITS-1:0]     w_frame;
  logic                      w_wp_fault;

  // The entry is fetched on the handshake edge, so it is ready throughout
  // XLATE and a table write landing during XLATE cannot affect this request.
  assign w_hs        = (r_state == ST_IDLE) && req_valid;
  assign w_pt_rd_idx = {pt_base, req_addr[LOGICAL_AW-1:PAGE_SHIFT]};
  assign w_frame     = w_entry[PTE_FRAME_LSB +: FRAME_BITS];

  cpu6_page_ram u_page_ram (
    .clk     (clock),
    .i_we    (pt_we),
    .i_waddr (pt_index),
    .i_wdata (pt_data),
    .i_re    (w_hs),
    .i_raddr (w_pt_rd_idx),
    .o_rdata (w_entry)
  );

`ifdef CPU6_MMU_WP_EN
  assign w_wp_fault = r_write & w_entry[PTE_WP_BIT];
`else
  // Bit 7 is stored in the table but carries no meaning in this build
  logic w_unused_wp;
  assign w_unused_wp = w_entry[PTE_WP_BIT];
  assign w_wp_fault  = 1'b0;
`endif

  // Request sequencer: IDLE -> XLATE -> ACCESS (timed) -> DONE -> IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_write     <= 1'b0;
      r_off       <= '0;
      r_cnt       <= 4'd0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_rsp_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_off       <= req_addr[PAGE_SHIFT-1:0];
            r_mem_wdata <= req_wdata;
            r_ready     <= 1'b0;
            r_state     <= ST_XLATE;
          end
        end
        ST_XLATE: begin
          if (w_wp_fault) begin
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= 1'b1;
            r_rsp_rdata <= 8'hFF;
            r_state     <= ST_DONE;
          end else begin
            r_mem_addr  <= {w_frame, r_off};
            r_mem_rd    <= ~r_write;
            r_mem_wr    <= r_write;
            r_cnt       <= 4'(WAIT_STATES);
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // mem_wait only matters once the programmed wait states are spent
          if (r_cnt == 4'd0) begin
            if (!mem_wait) begin
              r_mem_rd    <= 1'b0;
              r_mem_wr    <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= r_write ? 8'h00 : mem_rdata;
              r_state     <= ST_DONE;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          r_rsp_valid <= 1'b0;
          r_rsp_fault <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_fault = r_rsp_fault;
  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cpu6_mmu_bus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu6_mmu_bus
//  Description : Self-checking bench for cpu6_mmu_bus. A table-level model
//                (page table array + timing rules) predicts address, strobe
//                count, response latency, data and fault for each request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu6_mmu_bus;

  localparam int W = 2;
`ifdef CPU6_MMU_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_fault;
  logic [2:0]  pt_base = 3'd0;
  logic        pt_we = 1'b0;
  logic [7:0]  pt_index = 8'h00;
  logic [7:0]  pt_data = 8'h00;
  logic [17:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_wait = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [7:0] pt_model [256];

  typedef struct {
    int          rsp_k;
    int          rsp_n;
    int          rd_n;
    int          wr_n;
    logic [17:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        fault;
    int          ready_k;
    bit          unstable;
  } obs_t;

  cpu6_mmu_bus #(.WAIT_STATES(W), .FRAME_BITS(7)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .pt_base(pt_base), .pt_we(pt_we), .pt_index(pt_index), .pt_data(pt_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_wait(mem_wait)
  );

  always #5 clock = ~clock;

  // Expected outcome of one request from the table contents and timing rules
  function automatic obs_t model_req(input logic w, input logic [15:0] a,
                                     input logic [7:0] wd, input logic [2:0] base,
                                     input int stretch, input logic [7:0] rd);
    obs_t e;
    logic [7:0] ent;
    int idx;
    idx = base * 32 + (a / 2048);
    ent = pt_model[idx];
    e.fault    = WP_EN && w && ent[7];
    e.addr     = ent[6:0] * 18'd2048 + 18'(a % 2048);
    e.wdata    = wd;
    e.rsp_n    = 1;
    e.rsp_k    = e.fault ? 2 : 3 + W + stretch;
    e.rd_n     = (!w && !e.fault) ? W + 1 + stretch : 0;
    e.wr_n     = (w && !e.fault) ? W + 1 + stretch : 0;
    e.rdata    = e.fault ? 8'hFF : (w ? 8'h00 : rd);
    e.ready_k  = e.rsp_k + 1;
    e.unstable = 1'b0;
    return e;
  endfunction

  task automatic pt_write(input logic [7:0] idx, input logic [7:0] d);
    @(negedge clock);
    pt_we = 1'b1; pt_index = idx; pt_data = d;
    @(posedge clock);
    #1 pt_we = 1'b0;
    pt_model[idx] = d;
  endtask

  // Issue one request and observe the whole transaction cycle by cycle.
  // k counts negedges after the handshake edge (k=1 is the XLATE cycle).
  task automatic run_req(input logic w, input logic [15:0] a, input logic [7:0] wd,
                         input logic [2:0] base, input int stretch, input logic [7:0] rd,
                         input bit ptw, input logic [7:0] ptw_idx, input logic [7:0] ptw_data,
                         output obs_t o);
    int g;
    int n;
    o.rsp_k = -1; o.rsp_n = 0; o.rd_n = 0; o.wr_n = 0; o.addr = '0; o.wdata = '0;
    o.rdata = '0; o.fault = 1'b0; o.ready_k = -1; o.unstable = 1'b0;
    n = 0;
    g = 0;
    while (req_ready !== 1'b1 && g < 40) begin
      @(negedge clock);
      g++;
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; pt_base = base;
    mem_wait = 1'b0;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_addr  = 16'($urandom);
    pt_base   = 3'($urandom);
    if (ptw) begin
      pt_we = 1'b1; pt_index = ptw_idx; pt_data = ptw_data;
    end
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (req_ready === 1'b1 && o.ready_k < 0) o.ready_k = k;
      if (mem_rd === 1'b1 || mem_wr === 1'b1) begin
        n++;
        if (mem_rd === 1'b1) o.rd_n++;
        if (mem_wr === 1'b1) o.wr_n++;
        if (n == 1) begin
          o.addr  = mem_addr;
          o.wdata = mem_wdata;
        end else if (mem_addr !== o.addr) begin
          o.unstable = 1'b1;
        end
        mem_wait  = (n < W + 1 + stretch);
        mem_rdata = (n == W + 1 + stretch) ? rd : ~rd;
      end else begin
        mem_wait  = 1'($urandom);
        mem_rdata = 8'($urandom);
      end
      if (rsp_valid === 1'b1) begin
        o.rsp_n++;
        if (o.rsp_k < 0) begin
          o.rsp_k = k; o.rdata = rsp_rdata; o.fault = rsp_fault;
        end
      end
      if (k == 1 && ptw) begin
        @(posedge clock);
        #1 pt_we = 1'b0;
      end
      if (o.ready_k >= 0 && o.rsp_k >= 0) break;
    end
    mem_wait = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    total++;
    if ({mem_rd, mem_wr, rsp_valid, rsp_fault} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {mem_rd, mem_wr, rsp_valid, rsp_fault});
    end
    total++;
    if ({mem_addr, mem_wdata, rsp_rdata} !== 34'd0) begin
      bad++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, rsp_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_read_basic();
    obs_t o;
    run_req(1'b0, 16'h1234, 8'h00, 3'd0, 0, 8'h5A, 1'b0, 8'h00, 8'h00, o);
    total++;
    if (o.addr !== 18'h01234 || o.rd_n != 3 || o.wr_n != 0) begin
      bad++; $display("FAIL read_basic_bus: got addr=%h rd=%0d wr=%0d want 01234/3/0", o.addr, o.rd_n, o.wr_n);
    end
    total++;
    if (o.rsp_k != 5 || o.rdata !== 8'h5A || o.rsp_n != 1 || o.ready_k != 6) begin
      bad++; $display("FAIL read_basic_rsp: got k=%0d data=%h n=%0d rdy=%0d want 5/5a/1/6", o.rsp_k, o.rdata, o.rsp_n, o.ready_k);
    end
  endtask

  task automatic test_write_basic();
    obs_t o;
    pt_write(8'h25, 8'h41);
    run_req(1'b1, 16'h2ABC, 8'h77, 3'd1, 0, 8'h99, 1'b0, 8'h00, 8'h00, o);
    total++;
    if (o.addr !== 18'h20ABC || o.wr_n != 3 || o.rd_n != 0 || o.wdata !== 8'h77) begin
      bad++; $display("FAIL write_basic_bus: got addr=%h wr=%0d rd=%0d wd=%h want 20abc/3/0/77", o.addr, o.wr_n, o.rd_n, o.wdata);
    end
    total++;
    if (o.rsp_k != 5 || o.rdata !== 8'h00 || o.fault !== 1'b0) begin
      bad++; $display("FAIL write_basic_rsp: got k=%0d data=%h f=%b want 5/00/0", o.rsp_k, o.rdata, o.fault);
    end
  endtask

  task automatic test_wait_stretch();
    obs_t o;
    run_req(1'b0, 16'h1234, 8'h00, 3'd0, 4, 8'hC3, 1'b0, 8'h00, 8'h00, o);
    total++;
    if (o.rsp_k != 9 || o.rd_n != 7 || o.rdata !== 8'hC3) begin
      bad++; $display("FAIL wait_stretch: got k=%0d rd=%0d data=%h want 9/7/c3", o.rsp_k, o.rd_n, o.rdata);
    end
  endtask

  task automatic test_wrap();
    obs_t o;
    pt_write(8'h1F, 8'h7F);
    run_req(1'b0, 16'hFFFF, 8'h00, 3'd0, 0, 8'h3C, 1'b0, 8'h00, 8'h00, o);
    total++;
    if (o.addr !== 18'h3FFFF || o.unstable) begin
      bad++; $display("FAIL wrap_addr: got %h unstable=%b want 3ffff", o.addr, o.unstable);
    end
  endtask

  task automatic test_collision();
    obs_t o;
    run_req(1'b0, 16'h4800, 8'h00, 3'd2, 0, 8'h11, 1'b1, 8'h49, 8'h33, o);
    pt_model[8'h49] = 8'h33;
    total++;
    if (o.addr !== 18'h04800) begin
      bad++; $display("FAIL collision_old: got %h want 04800", o.addr);
    end
    run_req(1'b0, 16'h4800, 8'h00, 3'd2, 0, 8'h11, 1'b0, 8'h00, 8'h00, o);
    total++;
    if (o.addr !== 18'h19800) begin
      bad++; $display("FAIL collision_new: got %h want 19800", o.addr);
    end
  endtask

  task automatic test_write_protect();
    obs_t o;
    obs_t e;
    pt_write(8'h00, 8'h85);
    e = model_req(1'b1, 16'h0010, 8'hAB, 3'd0, 0, 8'h00);
    run_req(1'b1, 16'h0010, 8'hAB, 3'd0, 0, 8'h00, 1'b0, 8'h00, 8'h00, o);
    total++;
    if (o.wr_n != e.wr_n || o.rsp_k != e.rsp_k || o.fault !== e.fault || o.rdata !== e.rdata) begin
      bad++; $display("FAIL wp_write: got wr=%0d k=%0d f=%b d=%h want %0d/%0d/%b/%h",
                      o.wr_n, o.rsp_k, o.fault, o.rdata, e.wr_n, e.rsp_k, e.fault, e.rdata);
    end
    run_req(1'b0, 16'h0010, 8'h00, 3'd0, 0, 8'h6E, 1'b0, 8'h00, 8'h00, o);
    total++;
    if (o.addr !== 18'h02810 || o.rd_n != 3 || o.fault !== 1'b0 || o.rdata !== 8'h6E) begin
      bad++; $display("FAIL wp_read: got addr=%h rd=%0d f=%b d=%h want 02810/3/0/6e", o.addr, o.rd_n, o.fault, o.rdata);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int g;
    int seen;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1234; pt_base = 3'd0; mem_wait = 1'b0;
    @(posedge clock);
    #1 req_valid = 1'b0;
    g = 0;
    do begin
      @(negedge clock);
      g++;
    end while (mem_rd !== 1'b1 && g < 10);
    total++;
    if (mem_rd !== 1'b1) begin
      bad++; $display("FAIL reset_mid_start: mem_rd got %b want 1", mem_rd);
    end
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || rsp_valid !== 1'b0 || mem_addr !== 18'd0) begin
      bad++; $display("FAIL reset_mid_strobes: got rd=%b wr=%b v=%b addr=%h want 0", mem_rd, mem_wr, rsp_valid, mem_addr);
    end
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (rsp_valid === 1'b1) seen++;
    end
    total++;
    if (seen != 0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid_drop: got rsp pulses=%0d ready=%b want 0/1", seen, req_ready);
    end
    // table survives reset
    run_req(1'b0, 16'h2ABC, 8'h00, 3'd1, 0, 8'h42, 1'b0, 8'h00, 8'h00, o);
    total++;
    if (o.addr !== 18'h20ABC || o.rdata !== 8'h42) begin
      bad++; $display("FAIL reset_mid_table: got addr=%h d=%h want 20abc/42", o.addr, o.rdata);
    end
  endtask

  task automatic test_random();
    obs_t o;
    obs_t e;
    logic w;
    logic [15:0] a;
    logic [7:0] wd;
    logic [7:0] rd;
    logic [2:0] base;
    logic [7:0] pidx;
    logic [7:0] pdat;
    int st;
    bit ptw;
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom); a = 16'($urandom); wd = 8'($urandom); rd = 8'($urandom);
      base = 3'($urandom); st = $urandom_range(0, 3);
      pdat = 8'($urandom);
      if ($urandom_range(0, 1) == 1) pt_write({base, a[15:11]}, pdat);
      ptw = ($urandom_range(0, 3) == 0);
      pidx = ptw ? {base, a[15:11]} : 8'($urandom);
      pdat = 8'($urandom);
      e = model_req(w, a, wd, base, st, rd);
      run_req(w, a, wd, base, st, rd, ptw, pidx, pdat, o);
      if (ptw) pt_model[pidx] = pdat;
      total++;
      if (o.rsp_k != e.rsp_k || o.rsp_n != e.rsp_n || o.ready_k != e.ready_k) begin
        bad++; $display("FAIL rand_timing[%0d]: got k=%0d n=%0d rdy=%0d want %0d/%0d/%0d",
                        i, o.rsp_k, o.rsp_n, o.ready_k, e.rsp_k, e.rsp_n, e.ready_k);
      end
      total++;
      if (o.rd_n != e.rd_n || o.wr_n != e.wr_n || o.unstable) begin
        bad++; $display("FAIL rand_strobes[%0d]: got rd=%0d wr=%0d unstable=%b want %0d/%0d/0",
                        i, o.rd_n, o.wr_n, o.unstable, e.rd_n, e.wr_n);
      end
      if (e.rd_n + e.wr_n > 0) begin
        total++;
        if (o.addr !== e.addr || (w && o.wdata !== e.wdata)) begin
          bad++; $display("FAIL rand_addr[%0d]: got addr=%h wd=%h want %h/%h", i, o.addr, o.wdata, e.addr, e.wdata);
        end
      end
      total++;
      if (o.rdata !== e.rdata || o.fault !== e.fault) begin
        bad++; $display("FAIL rand_rsp[%0d]: got d=%h f=%b want %h/%b", i, o.rdata, o.fault, e.rdata, e.fault);
      end
    end
  endtask

  initial begin
    for (int n = 0; n < 256; n++) pt_model[n] = 8'(n % 32);
    test_reset();
    test_read_basic();
    test_write_basic();
    test_wait_stretch();
    test_wrap();
    test_collision();
    test_write_protect();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
